// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package seg7_pkg;

   // Scheduler states
   typedef logic [1:0] state_t;
   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_SCAN  = 2'd1;
   localparam state_t ST_BLANK = 2'd2;

   // Hex nibble to gfedcba segment pattern, entry 15 first
   localparam logic [15:0][6:0] HEX_SEG = {
      7'h71, 7'h79, 7'h5E, 7'h39,   // F E D C
      7'h7C, 7'h77, 7'h6F, 7'h7F,   // B A 9 8
      7'h07, 7'h7D, 7'h6D, 7'h66,   // 7 6 5 4
      7'h4F, 7'h5B, 7'h06, 7'h3F    // 3 2 1 0
   };

   // Inactive pin levels for a given polarity (al = 1: lit at logic 0)
   function automatic logic [6:0] seg_off(input bit al);
      return {7{al}};
   endfunction

   function automatic logic dp_off(input bit al);
      return al;
   endfunction

   function automatic logic [7:0] dig_off8(input bit al);
      return {8{al}};
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Nibble to gfedcba segment pattern lookup (active-high).
// Latency: combinational.
// Backpressure: none.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nib,
   output logic [6:0] seg
);

   assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg7_scan_sched.sv
// Round-robin digit scan with blanking gap, PWM brightness and a double-buffered update port.
// Latency: all pins registered; new contents appear at the next frame boundary (or one cycle after capture when idle).
// Backpressure: upd_ready low while the shadow buffer holds an uncopied update.
module seg7_scan_sched
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int DWELL_CYCLES   = 20000,
   parameter int BLANK_CYCLES   = 200,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int DIG_ACTIVE_LOW = 0
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable,
   input  logic                    upd_valid,
   output logic                    upd_ready,
   input  logic [4*NUM_DIGITS-1:0] upd_digits,
   input  logic [NUM_DIGITS-1:0]   upd_dp,
   input  logic [NUM_DIGITS-1:0]   upd_blank,
   input  logic [3:0]              brightness,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   dig_en,
   output logic                    frame_tick
);

   localparam int DW   = $clog2(DWELL_CYCLES + 1);
   localparam int BW   = $clog2(BLANK_CYCLES + 1);
   localparam int IW   = $clog2(NUM_DIGITS);
   localparam int STEP = DWELL_CYCLES / 16;

   localparam logic [6:0]            SEG_OFF  = seg_off(SEG_ACTIVE_LOW != 0);
   localparam logic                  DP_OFF   = dp_off(SEG_ACTIVE_LOW != 0);
   localparam logic [7:0]            DIG_OFF8 = dig_off8(DIG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] DIG_OFF  = DIG_OFF8[NUM_DIGITS-1:0];

   state_t                  state, state_n;
   logic [IW-1:0]           idx, idx_n;
   logic [DW-1:0]           dwell, dwell_n;
   logic [DW-1:0]           on_time, on_time_n;
   logic [BW-1:0]           bcnt, bcnt_n;
   logic                    tick_n;

   logic [4*NUM_DIGITS-1:0] act_digits, act_digits_n, sh_digits;
   logic [NUM_DIGITS-1:0]   act_dp, act_dp_n, sh_dp;
   logic [NUM_DIGITS-1:0]   act_blank, act_blank_n, sh_blank;
   logic                    pending, pending_n;
   logic                    capture, copy;

   logic [3:0]              sel_nib;
   logic [6:0]              sel_seg;
   logic                    lit;
   logic [NUM_DIGITS-1:0]   onehot;

   // Next-state of the slot sequencer; enable low forces IDLE from any state
   always_comb begin
      state_n = state;
      idx_n   = idx;
      dwell_n = dwell;
      bcnt_n  = bcnt;
      tick_n  = 1'b0;
      if (!enable) begin
         state_n = ST_IDLE;
         idx_n   = '0;
         dwell_n = '0;
         bcnt_n  = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_n = ST_SCAN;
               idx_n   = '0;
               dwell_n = '0;
               bcnt_n  = '0;
            end
            ST_SCAN: begin
               if (dwell == DW'(DWELL_CYCLES - 1)) begin
                  state_n = ST_BLANK;
                  bcnt_n  = '0;
               end else begin
                  dwell_n = dwell + 1'b1;
               end
            end
            ST_BLANK: begin
               if (bcnt == BW'(BLANK_CYCLES - 1)) begin
                  state_n = ST_SCAN;
                  dwell_n = '0;
                  if (idx == IW'(NUM_DIGITS - 1)) begin
                     idx_n  = '0;
                     tick_n = 1'b1;
                  end else begin
                     idx_n = idx + 1'b1;
                  end
               end else begin
                  bcnt_n = bcnt + 1'b1;
               end
            end
            default: begin
               state_n = ST_IDLE;
               idx_n   = '0;
               dwell_n = '0;
               bcnt_n  = '0;
            end
         endcase
      end
   end

   // Brightness is latched only on slot entry so a mid-slot change waits for the next slot
   always_comb begin
      on_time_n = on_time;
      if (state_n == ST_SCAN && dwell_n == '0)
         on_time_n = DW'((32'(brightness) + 32'd1) * STEP);
   end

   // Shadow-to-active transfer and handshake bookkeeping
   always_comb begin
      capture     = upd_valid && upd_ready;
      copy        = pending && (tick_n || state == ST_IDLE);
      pending_n   = capture || (pending && !copy);
      act_digits_n = copy ? sh_digits : act_digits;
      act_dp_n     = copy ? sh_dp     : act_dp;
      act_blank_n  = copy ? sh_blank  : act_blank;
   end

   // Pin values are computed from next-state so outputs line up with the registered state
   always_comb begin
      sel_nib = act_digits_n[{idx_n, 2'b00} +: 4];
      lit     = (state_n == ST_SCAN) && (dwell_n < on_time_n) && !act_blank_n[idx_n];
      onehot  = '0;
      onehot[idx_n] = 1'b1;
   end

   seg7_hex_decode u_dec (
      .nib (sel_nib),
      .seg (sel_seg)
   );

   // Sequencer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         idx     <= '0;
         dwell   <= '0;
         bcnt    <= '0;
         on_time <= '0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         dwell   <= dwell_n;
         bcnt    <= bcnt_n;
         on_time <= on_time_n;
      end
   end

   // Double buffer: shadow captures on handshake, active reloads from shadow on copy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_digits  <= '0;
         sh_dp      <= '0;
         sh_blank   <= '1;
         act_digits <= '0;
         act_dp     <= '0;
         act_blank  <= '1;
         pending    <= 1'b0;
         upd_ready  <= 1'b0;
      end else begin
         if (capture) begin
            sh_digits <= upd_digits;
            sh_dp     <= upd_dp;
            sh_blank  <= upd_blank;
         end
         act_digits <= act_digits_n;
         act_dp     <= act_dp_n;
         act_blank  <= act_blank_n;
         pending    <= pending_n;
         upd_ready  <= !pending_n;
      end
   end

   // Output pin registers with polarity applied; XOR with the off level flips active-low pins
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg        <= SEG_OFF;
         dp         <= DP_OFF;
         dig_en     <= DIG_OFF;
         frame_tick <= 1'b0;
      end else begin
         seg        <= lit ? (sel_seg ^ SEG_OFF) : SEG_OFF;
         dp         <= (lit && act_dp_n[idx_n]) ? !DP_OFF : DP_OFF;
         dig_en     <= lit ? (onehot ^ DIG_OFF) : DIG_OFF;
         frame_tick <= tick_n;
      end
   end

endmodule
